data_pair_map_lookup_arbiter: RTL
=================================

# data_pair_map_lookup_arbiter

Shares the single lookup port of a key→value pair-map table among REQN requesters. Requesters are granted round-robin, with one lookup outstanding at a time. The block steers the table's hit (out) and miss (err) returns back to the granted requester as a single tagged response. It sits between the requester logic and the map's read/out/err ports; the map's write and delete ports are not touched.

## Interface
- ISIZE, 8, key width
- OSIZE, 8, value width
- REQN, 4, number of requesters (≥2)
- TIMEOUT, 64, max WAIT cycles before a forced timeout response (used only with the macro)

- clock  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- req_valid  in  REQN  per-requester lookup request
- req_ready  out  REQN  per-requester accept (combinational)
- req_key  in  REQN*ISIZE  packed keys; requester i at [i*ISIZE+:ISIZE]
- rsp_valid  out  REQN  one-hot response valid
- rsp_ready  in  REQN  per-requester response accept
- rsp_hit  out  1  1 = key found
- rsp_timeout  out  1  1 = no map return within TIMEOUT
- rsp_data  out  OSIZE  value on hit, 0 otherwise
- map_rd_valid / map_rd_ready  out/in  1  map read request handshake
- map_rd_data  out  ISIZE  key to map
- map_out_valid / map_out_ready  in/out  1  map hit return
- map_out_data  in  OSIZE  value returned
- map_err_valid / map_err_ready  in/out  1  map miss return
- map_err_data  in  ISIZE  missed key (ignored except in checks)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant = first requester with req_valid searching from last_grant+1, wrapping modulo REQN.
  - req_ready[grant]=1 that cycle; latch key and grant; last_grant←grant; go ISSUE.
  - No req_valid: stay.
- ISSUE: map_rd_valid=1, map_rd_data=latched key. On map_rd_ready go WAIT.
  - Any out/err valid seen in ISSUE is stale and is consumed and discarded.
- WAIT: on map_out_valid capture hit=1, data=map_out_data. Otherwise on map_err_valid capture hit=0, data=0. Either return moves to RESP.
  - Both valid in the same cycle: out wins; err is also consumed.
- RESP: rsp_valid[grant]=1 with rsp_hit/rsp_data/rsp_timeout stable. On rsp_ready[grant] go IDLE.
  - rsp_ready of other requesters is ignored.
- map_out_ready = map_err_ready = 1 in IDLE, ISSUE and WAIT; 0 in RESP.
  - The map's read-ready follows out-ready, so out-ready is held high in ISSUE.
- Only one lookup is outstanding at a time; req_ready is 0 in all states except IDLE.
- Reset, including reset mid-operation: state→IDLE, last_grant→REQN-1 (requester 0 has first priority), all rsp_valid=0, map_rd_valid=0, rsp_hit=0, rsp_timeout=0, rsp_data=0, timeout counter=0. A map return still in flight after reset is drained in IDLE.

## Timing
- All outputs except req_ready, map_rd_ready-dependent transitions and the map_*_ready signals are registered.
- Minimum latency: request accept at cycle 0 → ISSUE at 1 → map accepts at 1 → map returns at 2 → rsp_valid at 3.
- Back-to-back: after an rsp handshake at cycle N, the next grant is possible at N+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,REQN-1,0.

## Configuration
- DATA_PAIR_MAP_ARB_TIMEOUT_EN defined:
  - a counter of width $clog2(TIMEOUT+1) runs in WAIT and clears on leaving WAIT.
  - When it reaches TIMEOUT, go RESP with hit=0, data=0, rsp_timeout=1.
  - A later map return lands in IDLE/ISSUE and is discarded.
- Not defined: WAIT waits indefinitely, rsp_timeout is tied 0, the counter is absent and TIMEOUT is unused.

## Structure
- Put the state enum typedef data_pair_arb_state_e in DataInterfacePkg.
- Sub-module rr_grant_arbiter (REQN): inputs req vector, last_grant and enable; outputs one-hot grant and index. It is reused for requester selection.

## Test plan
- Single requester 2, key 0x15, map returns out with value 0xA7 → rsp_valid[2] at cycle 3, rsp_hit=1, rsp_data=0xA7, rsp_timeout=0.
- Key 0x33, map returns err → rsp_hit=0, rsp_data=0x00, response only on the granted requester.
- All 4 requesters held valid for 8 lookups → grant order 0,1,2,3,0,1,2,3; no requester is starved.
- rsp_ready held low 5 cycles → rsp_valid and data stay stable; no new req_ready; map_out_ready=0 throughout.
- With the macro and TIMEOUT=4, map never returns → rsp_timeout=1, hit=0 after 4 WAIT cycles. A late map_out_valid in the next IDLE is consumed and produces no rsp_valid.
- rst asserted in WAIT → the next cycle is IDLE with all outputs at reset values; the first grant after reset goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/data_pair_map_lookup_arbiter_pkg.sv
// Shared types for the pair-map lookup arbiter.
// The lookup FSM state encoding lives here so the top module and the bench agree on it.
package DataInterfacePkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } data_pair_arb_state_e;

endpackage

// File: rtl/data_pair_map_lookup_arbiter_if.sv
// Bundle of requester-side and map-side handshakes around the lookup arbiter.
// slave: the arbiter's view. master: the surrounding requesters and map.
interface data_pair_map_lookup_arbiter_if #(
    parameter int REQN  = 4,
    parameter int ISIZE = 8,
    parameter int OSIZE = 8
) ();
    logic [REQN-1:0]       req_valid;
    logic [REQN-1:0]       req_ready;
    logic [REQN*ISIZE-1:0] req_key;
    logic [REQN-1:0]       rsp_valid;
    logic [REQN-1:0]       rsp_ready;
    logic                  rsp_hit;
    logic                  rsp_timeout;
    logic [OSIZE-1:0]      rsp_data;
    logic                  map_rd_valid;
    logic                  map_rd_ready;
    logic [ISIZE-1:0]      map_rd_data;
    logic                  map_out_valid;
    logic                  map_out_ready;
    logic [OSIZE-1:0]      map_out_data;
    logic                  map_err_valid;
    logic                  map_err_ready;
    logic [ISIZE-1:0]      map_err_data;

    modport slave (
        input  req_valid, req_key, rsp_ready,
        input  map_rd_ready, map_out_valid, map_out_data, map_err_valid, map_err_data,
        output req_ready, rsp_valid, rsp_hit, rsp_timeout, rsp_data,
        output map_rd_valid, map_rd_data, map_out_ready, map_err_ready
    );

    modport master (
        output req_valid, req_key, rsp_ready,
        output map_rd_ready, map_out_valid, map_out_data, map_err_valid, map_err_data,
        input  req_ready, rsp_valid, rsp_hit, rsp_timeout, rsp_data,
        input  map_rd_valid, map_rd_data, map_out_ready, map_err_ready
    );
endinterface

// File: rtl/data_pair_map_lookup_arbiter_rr.sv
// Round-robin selector: picks the first asserted request after last_grant,
// wrapping modulo REQN. Purely combinational; grant is zero when disabled.
module rr_grant_arbiter #(
    parameter int REQN = 4,
    localparam int IW  = $clog2(REQN)
) (
    input  logic [REQN-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    input  logic            enable_i,
    output logic [REQN-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);
    // Scan offsets 1..REQN from the last winner; the last winner itself is checked last.
    always_comb begin
        logic found;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 1; k <= REQN; k++) begin
            if (enable_i && !found && req_i[(int'(last_grant_i) + k) % REQN]) begin
                found = 1'b1;
                grant_o[(int'(last_grant_i) + k) % REQN] = 1'b1;
                idx_o = IW'((int'(last_grant_i) + k) % REQN);
            end
        end
    end
endmodule

// File: rtl/data_pair_map_lookup_arbiter.sv
// Shares one pair-map lookup port among REQN requesters, one lookup in flight.
// Hit (out) and miss (err) returns come back as a single tagged response on the
// granted requester. Optional WAIT timeout: define DATA_PAIR_MAP_ARB_TIMEOUT_EN.
module data_pair_map_lookup_arbiter
    import DataInterfacePkg::*;
#(
    parameter int ISIZE   = 8,
    parameter int OSIZE   = 8,
    parameter int REQN    = 4,
    parameter int TIMEOUT = 64
) (
    input logic                            clock,
    input logic                            rst,
    data_pair_map_lookup_arbiter_if.slave  bus
);
    localparam int IW = $clog2(REQN);

    data_pair_arb_state_e state_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        last_q;
    logic [ISIZE-1:0]     key_q;
    logic                 rd_valid_q;
    logic [REQN-1:0]      rsp_valid_q;
    logic                 hit_q;
    logic [OSIZE-1:0]     data_q;
    logic [REQN-1:0]      gnt;
    logic [IW-1:0]        gidx;
    logic [ISIZE-1:0]     key_sel;

`ifdef DATA_PAIR_MAP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          to_q;
    assign bus.rsp_timeout = to_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // Arbitration only matters in IDLE, so the arbiter is gated there; this also
    // makes its grant vector directly usable as req_ready.
    rr_grant_arbiter #(.REQN(REQN)) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .enable_i     (state_q == ST_IDLE),
        .grant_o      (gnt),
        .idx_o        (gidx)
    );

    assign key_sel           = bus.req_key[int'(gidx)*ISIZE +: ISIZE];
    assign bus.req_ready     = gnt;
    // Returns are sunk everywhere but RESP so stale or post-reset returns drain.
    assign bus.map_out_ready = (state_q != ST_RESP);
    assign bus.map_err_ready = (state_q != ST_RESP);
    assign bus.map_rd_valid  = rd_valid_q;
    assign bus.map_rd_data   = key_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_hit       = hit_q;
    assign bus.rsp_data      = data_q;

    // The missed key is only informative; TIMEOUT is unused without the macro.
    logic unused_sink;
    assign unused_sink = ^{bus.map_err_data, 1'(TIMEOUT)};

    // Lookup FSM with all response/map-request outputs registered.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IW'(REQN - 1);
            key_q       <= '0;
            rd_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            hit_q       <= 1'b0;
            data_q      <= '0;
`ifdef DATA_PAIR_MAP_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        key_q      <= key_sel;
                        grant_q    <= gidx;
                        last_q     <= gidx;
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.map_rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.map_out_valid) begin
                        hit_q       <= 1'b1;
                        data_q      <= bus.map_out_data;
                        rsp_valid_q <= REQN'(1) << grant_q;
                        state_q     <= ST_RESP;
`ifdef DATA_PAIR_MAP_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end else if (bus.map_err_valid) begin
                        hit_q       <= 1'b0;
                        data_q      <= '0;
                        rsp_valid_q <= REQN'(1) << grant_q;
                        state_q     <= ST_RESP;
`ifdef DATA_PAIR_MAP_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        hit_q       <= 1'b0;
                        data_q      <= '0;
                        to_q        <= 1'b1;
                        rsp_valid_q <= REQN'(1) << grant_q;
                        state_q     <= ST_RESP;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        hit_q       <= 1'b0;
                        data_q      <= '0;
`ifdef DATA_PAIR_MAP_ARB_TIMEOUT_EN
                        to_q        <= 1'b0;
`endif
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
